dcache_wb_buffer: RTL

Write-back buffer between the data cache's miss/evict port and main memory. Dirty evictions from the cache are queued here and drained to memory in the background, so a miss fill does not wait behind the eviction. Fill reads from the cache check the buffer first: a hit is forwarded from the buffer, a miss goes to memory. Read fills take priority over drains.

---
 rtl/dcache_wb_pkg.sv | 21 ++
 rtl/dcache_wb_match.sv | 34 +++
 rtl/dcache_wb_buffer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_pkg.sv
// Shared types and sizing for the data-cache write-back buffer.
package dcache_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DRAIN   = 2'd2
  } wb_state_t;

  localparam int WB_DEPTH  = 4;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_PTR_W  = $clog2(WB_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/dcache_wb_match.sv
// Combinational youngest-match search over the live window [head, head+count).
module dcache_wb_match
  import dcache_wb_pkg::*;
#(
  parameter  int DEPTH  = WB_DEPTH,
  parameter  int ADDR_W = WB_ADDR_W,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
  input  logic [PTR_W-1:0]             head,
  input  logic [PTR_W:0]               count,
  input  logic [ADDR_W-1:0]            key,
  output logic                         hit,
  output logic [PTR_W-1:0]             idx
);

  logic [PTR_W-1:0] ptr;

  // Walking oldest to youngest lets the last match win.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    ptr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ptr = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && valid[ptr] && (addrs[ptr] == key)) begin
        hit = 1'b1;
        idx = ptr;
      end
    end
  end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the D-cache evict/fill port and memory.
// Optional DCACHE_WB_COALESCE_EN: pushes to a buffered, non-draining address overwrite in place.
module dcache_wb_buffer
  import dcache_wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              empty,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  // Handshakes: wb push fires on wb_valid && wb_ready; a fill is accepted on
  // rd_req && !rd_busy; mem_req holds its command until the mem_ack pulse.

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             head_q, tail_q;
  logic [PTR_W:0]               count_q;

  wb_state_t         state_q, state_d;
  logic              mem_req_d, mem_we_d, rd_valid_d, rd_busy_d;
  logic [ADDR_W-1:0] mem_addr_d, pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, rd_data_d;

  logic             rd_accept, rd_hit, rd_miss, pop, alloc, coalesce;
  logic [PTR_W-1:0] rd_idx, co_idx;

  dcache_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_match (
    .valid(valid_q), .addrs(addr_q), .head(head_q), .count(count_q),
    .key(rd_addr), .hit(rd_hit), .idx(rd_idx)
  );

`ifdef DCACHE_WB_COALESCE_EN
  logic co_hit;

  dcache_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_co_match (
    .valid(valid_q), .addrs(addr_q), .head(head_q), .count(count_q),
    .key(wb_addr), .hit(co_hit), .idx(co_idx)
  );

  // The head is off limits while it is, or is about to start, draining.
  assign coalesce = wb_valid && co_hit &&
                    !((co_idx == head_q) && ((state_q == DRAIN) || (state_d == DRAIN)));
`else
  assign co_idx   = '0;
  assign coalesce = 1'b0;
`endif

  assign rd_accept = rd_req && !rd_busy;
  assign rd_miss   = rd_accept && !rd_hit;
  assign pop       = (state_q == DRAIN) && mem_ack;
  assign wb_ready  = (count_q != FULL) || pop || coalesce;
  assign alloc     = wb_valid && wb_ready && !coalesce;
  assign empty     = (count_q == '0);
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data;
    rd_busy_d   = rd_busy;
    pend_addr_d = rd_accept ? rd_addr : pend_addr_q;
    if (rd_accept && rd_hit) begin
      rd_valid_d = 1'b1;
      rd_data_d  = data_q[rd_idx];
    end
    if (rd_miss) rd_busy_d = 1'b1;
    case (state_q)
      IDLE: begin
        // rd_busy high in IDLE means a miss was parked behind a drain.
        if (rd_miss || rd_busy) begin
          state_d    = RD_WAIT;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = rd_busy ? pend_addr_q : rd_addr;
        end else if (!empty) begin
          state_d     = DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = data_q[head_q];
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          rd_valid_d = 1'b1;
          rd_data_d  = mem_rdata;
          rd_busy_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_busy     <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      rd_valid    <= rd_valid_d;
      rd_data     <= rd_data_d;
      rd_busy     <= rd_busy_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Pop is applied before alloc so a full-buffer push+pop reusing one slot stays valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= wb_addr;
        data_q[tail_q]  <= wb_data;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (coalesce) data_q[co_idx] <= wb_data;
      case ({alloc, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
